// File: rtl/block_pool_manager.sv
// Platform pool for a vertical scroller: on each view move, slots that fell
// below the view are respawned above the highest platform using an LFSR.
module block_pool_manager #(
   parameter int unsigned SCREEN_WIDTH = 400,
   parameter int unsigned BLOCK_WIDTH  = 40,
   parameter int unsigned NUM_SLOTS    = 16,
   parameter int unsigned SPAWN_GAP    = 40,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   localparam int unsigned IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   newView,
   input  logic [31:0]            minY,
   input  logic                   hasCollide,
   input  logic [IW-1:0]          collisionIdx,
   output logic [NUM_SLOTS*32-1:0] blocksX,
   output logic [NUM_SLOTS*32-1:0] blocksY,
   output logic [NUM_SLOTS-1:0]   isBlockActive,
   output logic [NUM_SLOTS-1:0]   isBreakable,
   output logic [31:0]            topY,
   output logic                   busy,
   output logic                   viewDone
);

   localparam int unsigned COLS = SCREEN_WIDTH / BLOCK_WIDTH;
   localparam int unsigned K    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [15:0] SEED = (LFSR_SEED == 16'd0) ? 16'd1 : LFSR_SEED;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} stateT;

   stateT                stateQ, stateD;
   logic [IW-1:0]        idxQ, idxD;
   logic [31:0]          minYQ, minYD;
   logic [31:0]          topYQ, topYD;
   logic [15:0]          lfsrQ, lfsrD;
   logic [31:0]          xQ [NUM_SLOTS];
   logic [31:0]          xD [NUM_SLOTS];
   logic [31:0]          yQ [NUM_SLOTS];
   logic [31:0]          yD [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] actQ, actD;
   logic [NUM_SLOTS-1:0] brkQ, brkD;

   logic [K-1:0] rawCol;
   logic [31:0]  col0, col1, colSel, spawnX, spawnY;
   logic [15:0]  lfsrNext;

   // Column folds an out-of-range LFSR draw back into the playfield once, else column 0
   always_comb begin
      rawCol   = lfsrQ[K-1:0];
      col0     = 32'(rawCol);
      col1     = col0 - COLS;
      colSel   = (col0 < COLS) ? col0 : ((col1 < COLS) ? col1 : 32'd0);
      spawnX   = 32'(colSel * BLOCK_WIDTH);
      spawnY   = topYQ + SPAWN_GAP;
      lfsrNext = lfsrQ[0] ? ((lfsrQ >> 1) ^ 16'hB400) : (lfsrQ >> 1);
   end

   always_comb begin
      stateD = stateQ;
      idxD   = idxQ;
      minYD  = minYQ;
      topYD  = topYQ;
      lfsrD  = lfsrQ;
      xD     = xQ;
      yD     = yQ;
      actD   = actQ;
      brkD   = brkQ;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (hasCollide && collisionIdx == IW'(i) && actQ[i] && brkQ[i]) begin
            actD[i] = 1'b0;
         end
      end
      case (stateQ)
         IDLE: begin
            if (newView) begin
               minYD  = minY;
               idxD   = '0;
               stateD = SCAN;
            end
         end
         SCAN: begin
            // Respawn is written after the collision clear so it overrides it
            if (!actQ[idxQ] || yQ[idxQ] < minYQ) begin
               yD[idxQ]   = spawnY;
               topYD      = spawnY;
               xD[idxQ]   = spawnX;
               brkD[idxQ] = lfsrQ[15];
               actD[idxQ] = 1'b1;
               lfsrD      = lfsrNext;
            end
            if (idxQ == IW'(NUM_SLOTS - 1)) begin
               stateD = DONE;
            end else begin
               idxD = idxQ + 1'b1;
            end
         end
         DONE:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= IDLE;
         idxQ   <= '0;
         minYQ  <= '0;
         topYQ  <= 32'((NUM_SLOTS - 1) * SPAWN_GAP);
         lfsrQ  <= SEED;
         actQ   <= '1;
         brkQ   <= '0;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            xQ[i] <= 32'((i % COLS) * BLOCK_WIDTH);
            yQ[i] <= 32'(i * SPAWN_GAP);
         end
      end else begin
         stateQ <= stateD;
         idxQ   <= idxD;
         minYQ  <= minYD;
         topYQ  <= topYD;
         lfsrQ  <= lfsrD;
         actQ   <= actD;
         brkQ   <= brkD;
         xQ     <= xD;
         yQ     <= yD;
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : gPack
      assign blocksX[32*g +: 32] = xQ[g];
      assign blocksY[32*g +: 32] = yQ[g];
   end

   assign isBlockActive = actQ;
   assign isBreakable   = brkQ;
   assign topY          = topYQ;
   assign busy          = (stateQ != IDLE);
   assign viewDone      = (stateQ == DONE);

endmodule

// File: tb/tb_block_pool_manager.sv
// Randomized bench for block_pool_manager with a slot-array reference model
// compared every cycle, plus literal expectations for the documented scenarios.
module tb_block_pool_manager;

   localparam int NS   = 16;
   localparam int COLS = 10;
   localparam int BW   = 40;
   localparam int GAP  = 40;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          newView = 1'b0;
   logic [31:0]   minY = '0;
   logic          hasCollide = 1'b0;
   logic [3:0]    collisionIdx = '0;
   logic [NS*32-1:0] blocksX, blocksY;
   logic [NS-1:0] isBlockActive, isBreakable;
   logic [31:0]   topY;
   logic          busy, viewDone;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   block_pool_manager dut (
      .clk(clk), .reset(reset), .newView(newView), .minY(minY),
      .hasCollide(hasCollide), .collisionIdx(collisionIdx),
      .blocksX(blocksX), .blocksY(blocksY), .isBlockActive(isBlockActive),
      .isBreakable(isBreakable), .topY(topY), .busy(busy), .viewDone(viewDone)
   );

   // Reference pool: plain arrays plus a phase counter (0 idle, 1..NS slot, NS+1 done)
   logic [31:0] mX [NS];
   logic [31:0] mY [NS];
   logic        mAct [NS];
   logic        mBrk [NS];
   logic [31:0] mTop, mMin;
   logic [15:0] mLfsr;
   int          mPhase;
   bit          mValid = 1'b0;
   int          slot, killIdx;
   bit          kill;

   function automatic logic [15:0] lfsrStep(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic logic [31:0] colX(input logic [15:0] v);
      int c;
      c = int'(v % 16);
      if (c >= COLS) c = c - COLS;
      if (c >= COLS) c = 0;
      return 32'(c * BW);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NS; i++) begin
         mX[i]   = 32'((i % COLS) * BW);
         mY[i]   = 32'(i * GAP);
         mAct[i] = 1'b1;
         mBrk[i] = 1'b0;
      end
      mTop   = 32'((NS - 1) * GAP);
      mLfsr  = 16'hACE1;
      mPhase = 0;
      mMin   = '0;
      mValid = 1'b1;
   endtask

   // Model advance on every clock, from the same inputs the DUT samples
   always @(posedge clk) begin
      if (reset) begin
         modelReset();
      end else if (mValid) begin
         killIdx = int'(collisionIdx);
         kill    = hasCollide && mAct[killIdx] && mBrk[killIdx];
         slot    = -1;
         if (mPhase >= 1 && mPhase <= NS) begin
            if (!mAct[mPhase-1] || mY[mPhase-1] < mMin) begin
               slot        = mPhase - 1;
               mTop        = mTop + GAP;
               mY[slot]    = mTop;
               mX[slot]    = colX(mLfsr);
               mBrk[slot]  = mLfsr[15];
               mAct[slot]  = 1'b1;
               mLfsr       = lfsrStep(mLfsr);
            end
         end
         if (kill && killIdx != slot) mAct[killIdx] = 1'b0;
         if (mPhase == 0) begin
            if (newView) begin
               mMin   = minY;
               mPhase = 1;
            end
         end else if (mPhase <= NS) begin
            mPhase = mPhase + 1;
         end else begin
            mPhase = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
      checks++;
      if (actual === expected) passed++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
   endtask

   logic [NS*32-1:0] eX, eY;
   logic [NS-1:0]    eA, eB;

   always @(negedge clk) begin
      if (mValid) begin
         for (int i = 0; i < NS; i++) begin
            eX[32*i +: 32] = mX[i];
            eY[32*i +: 32] = mY[i];
            eA[i] = mAct[i];
            eB[i] = mBrk[i];
         end
         checkOutput("model blocksX", blocksX, eX);
         checkOutput("model blocksY", blocksY, eY);
         checkOutput("model isBlockActive", isBlockActive, eA);
         checkOutput("model isBreakable", isBreakable, eB);
         checkOutput("model topY", topY, mTop);
         checkOutput("model busy", busy, (mPhase != 0));
         checkOutput("model viewDone", viewDone, (mPhase == NS + 1));
      end
   end

   task automatic applyStimulus(input bit nv, input logic [31:0] my, input bit hc, input logic [3:0] ci);
      newView      = nv;
      minY         = my;
      hasCollide   = hc;
      collisionIdx = ci;
      @(posedge clk);
      #2;
      newView    = 1'b0;
      hasCollide = 1'b0;
   endtask

   // Launch a view move and count busy/viewDone cycles over a bounded window
   task automatic runScan(input logic [31:0] my, input int secondAt, output int busyCnt, output int doneCnt);
      busyCnt = 0;
      doneCnt = 0;
      applyStimulus(1'b1, my, 1'b0, 4'd0);
      for (int c = 0; c < 40; c++) begin
         if (busy) busyCnt++;
         if (viewDone) doneCnt++;
         if (c == secondAt) applyStimulus(1'b1, my + 5, 1'b0, 4'd0);
         else applyStimulus(1'b0, my, 1'b0, 4'd0);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " slot3 X"}, blocksX[3*32 +: 32], 32'd120);
      checkOutput({tag, " slot3 Y"}, blocksY[3*32 +: 32], 32'd120);
      checkOutput({tag, " slot3 active"}, isBlockActive[3], 1'b1);
      checkOutput({tag, " slot12 X"}, blocksX[12*32 +: 32], 32'd80);
      checkOutput({tag, " slot12 Y"}, blocksY[12*32 +: 32], 32'd480);
      checkOutput({tag, " topY"}, topY, 32'd600);
      checkOutput({tag, " busy"}, busy, 1'b0);
      checkOutput({tag, " viewDone"}, viewDone, 1'b0);
      checkOutput({tag, " breakable"}, isBreakable, 16'h0000);
   endtask

   int bCnt, dCnt;

   initial begin
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      checkResetState("reset");

      // No slot below minY=0: nothing moves and the LFSR must stay at its seed
      runScan(32'd0, -1, bCnt, dCnt);
      checkOutput("minY0 busy cycles", 32'(bCnt), 32'd17);
      checkOutput("minY0 viewDone pulses", 32'(dCnt), 32'd1);
      checkOutput("minY0 topY", topY, 32'd600);
      checkOutput("minY0 slot0 X", blocksX[31:0], 32'd0);

      // Slots 0..2 lie below 100 and respawn from the untouched seed 16'hACE1
      runScan(32'd100, -1, bCnt, dCnt);
      checkOutput("minY100 busy cycles", 32'(bCnt), 32'd17);
      checkOutput("minY100 viewDone pulses", 32'(dCnt), 32'd1);
      checkOutput("minY100 slot0 Y", blocksY[0*32 +: 32], 32'd640);
      checkOutput("minY100 slot1 Y", blocksY[1*32 +: 32], 32'd680);
      checkOutput("minY100 slot2 Y", blocksY[2*32 +: 32], 32'd720);
      checkOutput("minY100 slot0 X", blocksX[0*32 +: 32], 32'd40);
      checkOutput("minY100 slot1 X", blocksX[1*32 +: 32], 32'd0);
      checkOutput("minY100 slot2 X", blocksX[2*32 +: 32], 32'd320);
      checkOutput("minY100 topY", topY, 32'd720);
      checkOutput("minY100 slot3 Y", blocksY[3*32 +: 32], 32'd120);
      checkOutput("minY100 slot0 breakable", isBreakable[0], 1'b1);
      checkOutput("minY100 slot2 breakable", isBreakable[2], 1'b0);

      applyStimulus(1'b0, 32'd0, 1'b1, 4'd5);
      checkOutput("collide solid slot5 active", isBlockActive[5], 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1, 4'd0);
      checkOutput("collide breakable slot0 active", isBlockActive[0], 1'b0);
      checkOutput("collide slot0 keeps Y", blocksY[31:0], 32'd640);

      // Second newView mid-scan must not produce a second completion
      runScan(32'd700, 5, bCnt, dCnt);
      checkOutput("double newView pulses", 32'(dCnt), 32'd1);
      checkOutput("double newView busy cycles", 32'(bCnt), 32'd17);
      checkOutput("slot0 respawned", isBlockActive[0], 1'b1);

      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 7) == 0, mTop - 32'($urandom_range(0, 800)),
                       $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
      end
      for (int n = 0; n < 20; n++) applyStimulus(1'b0, 32'd0, 1'b0, 4'd0);

      // Reset landing while the scan is on slot 7
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 4'd0);
      for (int n = 0; n < 7; n++) applyStimulus(1'b0, 32'd0, 1'b0, 4'd0);
      checkOutput("pre-reset busy", busy, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      checkResetState("midscan reset");
      applyStimulus(1'b0, 32'd0, 1'b0, 4'd0);
      checkOutput("post-reset idle", busy, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
